// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: datapath defaults, RV32I load
// funct3 codes and the FSM state encoding.
package wb_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;

  // RV32I load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational little-endian load extraction.
// Ports:
//   rdata   - aligned word returned by data memory
//   funct3  - load width/sign code
//   addr_lo - byte offset of the load within the word
//   data    - extracted, sign/zero-extended result
//   legal   - 0 for misaligned halfword/word or unknown funct3
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            legal
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select: byte by full offset, halfword by offset bit 1
  always_comb begin
    byte_v = 8'(rdata >> {addr_lo, 3'b000});
    half_v = 16'(rdata >> {addr_lo[1], 4'b0000});
  end

  always_comb begin
    data  = rdata;
    legal = 1'b0;
    case (funct3)
      F3_LB: begin
        data  = {{(XLEN-8){byte_v[7]}}, byte_v};
        legal = 1'b1;
      end
      F3_LBU: begin
        data  = {{(XLEN-8){1'b0}}, byte_v};
        legal = 1'b1;
      end
      F3_LH: begin
        data  = {{(XLEN-16){half_v[15]}}, half_v};
        legal = ~addr_lo[0];
      end
      F3_LHU: begin
        data  = {{(XLEN-16){1'b0}}, half_v};
        legal = ~addr_lo[0];
      end
      F3_LW: begin
        data  = rdata;
        legal = (addr_lo == 2'b00);
      end
      default: begin
        data  = rdata;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the in-order RV32I core. Retires instructions
// from MEM, waits for the data-memory response on loads, aligns load data and
// issues a single-cycle registered write to the register file.
// Ports:
//   clk, rst           - core clock, asynchronous active-high reset
//   in_valid/in_ready  - MEM-stage handshake (in_ready high only in IDLE)
//   in_rd, in_rd_we    - destination register and its write enable
//   in_is_load, in_funct3, in_addr_lo - load descriptor
//   in_result          - ALU/link result for non-loads
//   dmem_rvalid/rdata  - data-memory read response
//   write_reg, target_reg, write_rd_data - register-file write port
//   load_err           - one-cycle pulse for an illegal/misaligned load
//   spurious_err       - sticky: response arrived while not waiting for one
//   retire_cnt         - completed-instruction count (only with WB_RETIRE_CNT_EN)
// Configuration macro: WB_RETIRE_CNT_EN adds the retire_cnt output and counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic [XLEN-1:0]   in_result,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              write_reg,
  output logic [REG_AW-1:0] target_reg,
  output logic [XLEN-1:0]   write_rd_data,
  output logic              load_err,
  output logic              spurious_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  wb_state_e         state;
  logic [REG_AW-1:0] pend_rd;
  logic              pend_we;
  logic [2:0]        pend_funct3;
  logic [1:0]        pend_addr_lo;

  logic [XLEN-1:0]   al_data;
  logic              al_legal;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata   (dmem_rdata),
    .funct3  (pend_funct3),
    .addr_lo (pend_addr_lo),
    .data    (al_data),
    .legal   (al_legal)
  );

  // Stage FSM with registered register-file port; in_ready mirrors state==IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      write_reg     <= 1'b0;
      target_reg    <= '0;
      write_rd_data <= '0;
      load_err      <= 1'b0;
      spurious_err  <= 1'b0;
      pend_rd       <= '0;
      pend_we       <= 1'b0;
      pend_funct3   <= 3'b000;
      pend_addr_lo  <= 2'b00;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt    <= 64'd0;
`endif
    end else begin
      write_reg <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE: begin
          // A response with no load outstanding carries no usable data
          if (dmem_rvalid) begin
            spurious_err <= 1'b1;
          end
          if (in_valid) begin
            if (in_is_load) begin
              pend_rd      <= in_rd;
              pend_we      <= in_rd_we;
              pend_funct3  <= in_funct3;
              pend_addr_lo <= in_addr_lo;
              state        <= WAIT_LOAD;
              in_ready     <= 1'b0;
            end else begin
              write_reg     <= in_rd_we && (in_rd != '0);
              target_reg    <= in_rd;
              write_rd_data <= in_result;
`ifdef WB_RETIRE_CNT_EN
              retire_cnt    <= retire_cnt + 64'd1;
`endif
            end
          end
        end
        WAIT_LOAD: begin
          // Illegal loads still consume the response and complete
          if (dmem_rvalid) begin
            write_reg     <= pend_we && (pend_rd != '0) && al_legal;
            load_err      <= ~al_legal;
            target_reg    <= pend_rd;
            write_rd_data <= al_data;
            state         <= IDLE;
            in_ready      <= 1'b1;
`ifdef WB_RETIRE_CNT_EN
            retire_cnt    <= retire_cnt + 64'd1;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        write_reg;
  logic [4:0]  target_reg;
  logic [31:0] write_rd_data;
  logic        load_err;
  logic        spurious_err;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_rd_we      (in_rd_we),
    .in_is_load    (in_is_load),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_result     (in_result),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .write_reg     (write_reg),
    .target_reg    (target_reg),
    .write_rd_data (write_rd_data),
    .load_err      (load_err),
    .spurious_err  (spurious_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt    (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one outstanding load at most, expected port values
  bit          m_busy;
  logic [4:0]  m_rd;
  bit          m_we;
  logic [2:0]  m_f3;
  logic [1:0]  m_a;
  bit          e_wr, e_err, e_spur, e_upd;
  logic [4:0]  e_tgt;
  logic [31:0] e_data;
  longint unsigned e_cnt;

  // Returns {legal, value} from the ISA load rules using plain arithmetic
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return {1'b1, (b >= 32'd128) ? b + 32'hFFFF_FF00 : b};
      3'd4: return {1'b1, b};
      3'd1: return {a % 2 == 0, (h >= 32'd32768) ? h + 32'hFFFF_0000 : h};
      3'd5: return {a % 2 == 0, h};
      3'd2: return {a == 0, w};
      default: return {1'b0, w};
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rd = '0; m_we = 0; m_f3 = '0; m_a = '0;
    e_wr = 0; e_err = 0; e_spur = 0; e_upd = 0; e_tgt = '0; e_data = '0; e_cnt = 0;
  endtask

  task automatic model_update();
    logic [32:0] r;
    e_wr = 0; e_err = 0; e_upd = 0;
    if (!m_busy) begin
      if (dmem_rvalid) e_spur = 1;
      if (in_valid) begin
        if (in_is_load) begin
          m_busy = 1; m_rd = in_rd; m_we = in_rd_we; m_f3 = in_funct3; m_a = in_addr_lo;
        end else begin
          e_wr = in_rd_we && (in_rd != 0);
          e_tgt = in_rd; e_data = in_result; e_upd = 1; e_cnt++;
        end
      end
    end else if (dmem_rvalid) begin
      r = ref_load(m_f3, int'(m_a), dmem_rdata);
      e_wr = r[32] && m_we && (m_rd != 0);
      e_err = !r[32];
      e_upd = r[32];
      e_tgt = m_rd; e_data = r[31:0];
      m_busy = 0; e_cnt++;
    end
  endtask

  task automatic check_outputs();
    check("write_reg", 64'(write_reg), 64'(e_wr));
    check("load_err", 64'(load_err), 64'(e_err));
    check("spurious_err", 64'(spurious_err), 64'(e_spur));
    check("in_ready", 64'(in_ready), 64'(!m_busy));
    if (e_upd) begin
      check("target_reg", 64'(target_reg), 64'(e_tgt));
      check("write_rd_data", 64'(write_rd_data), 64'(e_data));
    end
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, e_cnt);
`endif
  endtask

  // Inputs are applied away from the edge, then one clock is taken and checked
  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] f3, input logic [1:0] a, input logic [31:0] res,
                       input logic rv, input logic [31:0] rdat);
    in_valid = v; in_rd = rd; in_rd_we = we; in_is_load = ld; in_funct3 = f3;
    in_addr_lo = a; in_result = res; dmem_rvalid = rv; dmem_rdata = rdat;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_write_reg", 64'(write_reg), 64'd0);
    check("rst_target_reg", 64'(target_reg), 64'd0);
    check("rst_data", 64'(write_rd_data), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_spurious", 64'(spurious_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_rd = '0; in_rd_we = 0; in_is_load = 0; in_funct3 = '0;
    in_addr_lo = '0; in_result = '0; dmem_rvalid = 0; dmem_rdata = '0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Non-load rd=5, visible for exactly one cycle
    drive(1, 5'd5, 1, 0, 3'd0, 2'd0, 32'h1234_5678, 0, 32'd0);
    check("alu_wr", 64'(write_reg), 64'd1);
    check("alu_data", 64'(write_rd_data), 64'h1234_5678);
    idle();
    check("alu_one_cycle", 64'(write_reg), 64'd0);

    // LB addr 3, response three cycles after handshake
    drive(1, 5'd7, 1, 1, 3'd0, 2'd3, 32'd0, 0, 32'd0);
    idle();
    idle();
    drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 1, 32'h80FF_0000);
    check("lb_data", 64'(write_rd_data), 64'hFFFF_FF80);
    // LBU on the same word
    drive(1, 5'd8, 1, 1, 3'd4, 2'd3, 32'd0, 0, 32'd0);
    drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 1, 32'h80FF_0000);
    check("lbu_data", 64'(write_rd_data), 64'h0000_0080);

    // LH addr 2, then misaligned LH addr 1
    drive(1, 5'd9, 1, 1, 3'd1, 2'd2, 32'd0, 0, 32'd0);
    drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 1, 32'h8001_1234);
    check("lh_data", 64'(write_rd_data), 64'hFFFF_8001);
    drive(1, 5'd9, 1, 1, 3'd1, 2'd1, 32'd0, 0, 32'd0);
    drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 1, 32'h8001_1234);
    check("lh_mis_err", 64'(load_err), 64'd1);
    check("lh_mis_wr", 64'(write_reg), 64'd0);
    idle();

    // Back-to-back non-loads rd=0..3
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(i), 1, 0, 3'd0, 2'd0, 32'(i * 3 + 1), 0, 32'd0);
      check("b2b_wr", 64'(write_reg), 64'(i != 0));
    end

    // Spurious response, then reset in the middle of a load
    drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 1, 32'hDEAD_BEEF);
    check("spur_set", 64'(spurious_err), 64'd1);
    idle();
    drive(1, 5'd4, 1, 1, 3'd2, 2'd0, 32'd0, 0, 32'd0);
    apply_reset();
    drive(0, 5'd0, 0, 0, 3'd0, 2'd0, 32'd0, 1, 32'h0BAD_F00D);
    check("post_rst_wr", 64'(write_reg), 64'd0);
    apply_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic rv;
      rv = m_busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
      drive(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), $urandom,
            rv, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the in-order RV32I core; sits directly upstream of the register file and drives its write port (write_reg, target_reg, write_rd_data).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and waits for the data-memory response on loads.
- Performs load byte/halfword extraction with sign or zero extension, then presents a single-cycle registered write to the register file.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- in_rd  in  REG_AW  destination register.
- in_rd_we  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load.
- in_funct3  in  3  load width/sign code.
- in_addr_lo  in  2  load byte address [1:0].
- in_result  in  XLEN  ALU/link result for non-loads.
- dmem_rvalid  in  1  data-memory read response valid.
- dmem_rdata  in  XLEN  aligned 32-bit word read.
- write_reg  out  1  register-file write strobe.
- target_reg  out  REG_AW  register-file write index.
- write_rd_data  out  XLEN  register-file write data.
- load_err  out  1  one-cycle pulse on misaligned or illegal load.
- spurious_err  out  1  sticky flag: dmem_rvalid seen outside WAIT_LOAD.

Behaviour:
- Reset: state=IDLE; write_reg=0, target_reg=0, write_rd_data=0, load_err=0, spurious_err=0.
- All outputs are registered. write_reg is high for exactly one cycle per write; the register file samples it on the following negedge.
- FSM states: IDLE, WAIT_LOAD.
- IDLE, handshake (in_valid && in_ready), non-load:
  - Next cycle write_reg = in_rd_we && (in_rd != 0), target_reg = in_rd, write_rd_data = in_result.
  - State stays IDLE, so back-to-back non-loads retire one per cycle.
- IDLE, handshake, load:
  - Capture rd, rd_we, funct3 and addr_lo; go to WAIT_LOAD. write_reg = 0 next cycle.
- WAIT_LOAD, dmem_rvalid = 1:
  - Next cycle write_reg = rd_we && (rd != 0) && legal, with the extracted data.
  - Return to IDLE; in_ready rises the cycle after rvalid.
  - Minimum load latency is 2 cycles from handshake to write_reg.
- WAIT_LOAD, dmem_rvalid = 0: hold with in_ready = 0; no timeout.
- Load extraction (little-endian):
  - funct3 000 LB: byte at addr_lo*8, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at addr_lo[1]*16, sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word.
- Illegal loads: LH/LHU with addr_lo[0]=1, LW with addr_lo != 0, or any other funct3.
  - Response is consumed, write_reg = 0, load_err pulses in the same cycle the write would have occurred.
- rd = 0 never asserts write_reg; write_rd_data is still updated.
- dmem_rvalid in IDLE: ignored for data; spurious_err is set and stays set until reset.
- Reset mid-load: WAIT_LOAD is abandoned immediately and any pending write is dropped.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [63:0], reset to 0.
  - Increments by 1 in each cycle in which an instruction completes (non-load handshake, or rvalid in WAIT_LOAD), including illegal loads and rd = 0.
  - Wraps at 2^64.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - funct3 constants LB/LH/LW/LBU/LHU.
  - FSM state encoding (IDLE, WAIT_LOAD).
  - XLEN/REG_AW defaults.
- Sub-module load_align: combinational (rdata, funct3, addr_lo) -> (data, legal); instantiated once.

Test Plan:
- Reset then non-load handshake rd=5, result=0x1234_5678 -> next cycle write_reg=1, target_reg=5, write_rd_data=0x1234_5678, for one cycle only.
- LB, addr_lo=3, rdata=0x80FF_0000, rvalid 3 cycles after handshake -> write_rd_data=0xFFFF_FF80. LBU on the same word -> 0x0000_0080. in_ready low throughout WAIT_LOAD.
- LH, addr_lo=2, rdata=0x8001_1234 -> 0xFFFF_8001. LH with addr_lo=1 -> write_reg=0, load_err pulse, state returns to IDLE.
- Four back-to-back non-loads with rd=0,1,2,3 -> write_reg pattern 0,1,1,1 on consecutive cycles; in_ready stays 1.
- rvalid in IDLE -> spurious_err=1 and held; assert rst while in WAIT_LOAD -> all outputs 0, later rvalid produces no write.
- With WB_RETIRE_CNT_EN defined: run the sequences above -> retire_cnt equals the number of completed instructions.
